mux2_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared two-input 32-bit selector datapath. It accepts two valid/ready requester streams and drives the one-hot sel1/sel2 selects of the shared mux. The selected word is captured into a single output register with a valid/ready interface toward downstream logic. A burst limit bounds how long one requester can hold the shared path.

---
 rtl/mux2_arbiter.sv | 139 +++++++++++++
 tb/tb_mux2_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Round-robin two-requester arbiter driving the one-hot selects of a shared 32-bit mux into a registered output stage.
// Optional ARB_STATS_EN macro adds per-requester accepted-transfer counters with a synchronous clear.
module mux2_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  sel1,
    output logic                  sel2,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
`ifdef ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [31:0]           a_count,
    output logic [31:0]           b_count,
`endif
    output logic                  out_src
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t                  state, state_nxt;
    logic                    rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;
    logic                    can_load;
    logic                    a_xfer, b_xfer, load;
    logic [DATA_WIDTH-1:0]   mux_data;

    // Selects decode the state register directly so they stay glitch-free.
    always_comb begin
        sel1     = (state == OWN_A);
        sel2     = (state == OWN_B);
        can_load = !out_valid || out_ready;
        a_ready  = sel1 && can_load;
        b_ready  = sel2 && can_load;
        a_xfer   = a_valid && a_ready;
        b_xfer   = b_valid && b_ready;
        load     = a_xfer || b_xfer;
        mux_data = ({DATA_WIDTH{sel1}} & a_data) | ({DATA_WIDTH{sel2}} & b_data);
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) state_nxt = rr_ptr ? OWN_B : OWN_A;
                else if (a_valid)       state_nxt = OWN_A;
                else if (b_valid)       state_nxt = OWN_B;
            end
            OWN_A: begin
                if (a_xfer) begin
                    if (burst_cnt == LAST_BEAT) begin
                        burst_cnt_nxt = '0;
                        if (b_valid) begin
                            state_nxt  = OWN_B;
                            rr_ptr_nxt = 1'b1;
                        end
                    end else begin
                        burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    end
                end else if (!a_valid) begin
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = 1'b1;
                    state_nxt     = b_valid ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (b_xfer) begin
                    if (burst_cnt == LAST_BEAT) begin
                        burst_cnt_nxt = '0;
                        if (a_valid) begin
                            state_nxt  = OWN_A;
                            rr_ptr_nxt = 1'b0;
                        end
                    end else begin
                        burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    end
                end else if (!b_valid) begin
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = 1'b0;
                    state_nxt     = a_valid ? OWN_A : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (load) begin
                out_data  <= mux_data;
                out_valid <= 1'b1;
                out_src   <= sel2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_xfer) a_count <= a_count + 32'd1;
            if (b_xfer) b_count <= b_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Build with ARB_STATS_EN defined to also exercise the transfer counters.
module tb_mux2_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, sel1, sel2, out_valid, out_src;
    logic [31:0] out_data;
    logic        stats_clr = 1'b0;
`ifdef ARB_STATS_EN
    logic [31:0] a_count, b_count;
`endif

    mux2_arbiter #(.DATA_WIDTH(32), .MAX_BURST(MAXB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel1(sel1), .sel2(sel2),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr), .a_count(a_count), .b_count(b_count),
`endif
        .out_src(out_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Stimulus knobs driven by the directed steps and the random phase.
    bit          a_v, b_v, o_r, clr;
    logic [31:0] a_d, b_d;
    bit          last_acc_a, last_acc_b;
    int          n_a, n_b;

    // Behavioural model: owner 0=none 1=A 2=B; ptr 0=A 1=B; streak = transfers in this ownership.
    int          m_own, m_ptr, m_streak;
    bit          m_ov, m_os;
    logic [31:0] m_od;
    int unsigned m_ac, m_bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_own = 0; m_ptr = 0; m_streak = 0;
        m_ov = 0; m_os = 0; m_od = '0;
        m_ac = 0; m_bc = 0;
    endfunction

    function automatic void model_step(input bit take_a, input bit take_b);
        bit mine, other;
        if (clr) begin
            m_ac = 0; m_bc = 0;
        end else begin
            m_ac += take_a;
            m_bc += take_b;
        end
        if (take_a || take_b) begin
            m_ov = 1; m_od = take_a ? a_d : b_d; m_os = take_b;
        end else if (o_r) begin
            m_ov = 0;
        end
        if (m_own == 0) begin
            if (a_v && b_v) m_own = m_ptr + 1;
            else if (a_v)   m_own = 1;
            else if (b_v)   m_own = 2;
        end else begin
            mine  = (m_own == 1) ? a_v : b_v;
            other = (m_own == 1) ? b_v : a_v;
            if (take_a || take_b) begin
                m_streak++;
                if (m_streak == MAXB) begin
                    m_streak = 0;
                    if (other) begin
                        m_own = 3 - m_own;
                        m_ptr = m_own - 1;
                    end
                end
            end else if (!mine) begin
                m_streak = 0;
                m_ptr = (m_own == 1) ? 1 : 0;
                m_own = other ? 3 - m_own : 0;
            end
        end
    endfunction

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n = 0; a_valid = 1; b_valid = 1; out_ready = 1; stats_clr = 0;
        end
        @(negedge clk);
        #1;
        model_reset();
        last_acc_a = 0; last_acc_b = 0; n_a = 0; n_b = 0; clr = 0;
        chk("rst_sel1", sel1, 0);
        chk("rst_sel2", sel2, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
    endtask

    task automatic cycle();
        bit can, acc_a, acc_b;
        @(negedge clk);
        rst_n = 1;
        a_valid = a_v; a_data = a_d; b_valid = b_v; b_data = b_d;
        out_ready = o_r; stats_clr = clr;
        #1;
        can   = !m_ov || o_r;
        acc_a = (m_own == 1) && a_v && can;
        acc_b = (m_own == 2) && b_v && can;
        chk("sel1", sel1, m_own == 1);
        chk("sel2", sel2, m_own == 2);
        chk("a_ready", a_ready, (m_own == 1) && can);
        chk("b_ready", b_ready, (m_own == 2) && can);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_src", out_src, m_os);
`ifdef ARB_STATS_EN
        chk("a_count", a_count, m_ac);
        chk("b_count", b_count, m_bc);
`endif
        model_step(acc_a, acc_b);
        last_acc_a = acc_a; last_acc_b = acc_b;
        if (acc_a) begin n_a++; a_d = a_d + 1; end
        if (acc_b) begin n_b++; b_d = b_d + 1; end
    endtask

    initial begin
        // Reset held with both requesting, then grant goes to A.
        do_reset(3);
        a_v = 1; b_v = 1; o_r = 1; a_d = 32'h100; b_d = 32'h200;
        cycle();
        cycle();
        chk("post_reset_own_a", sel1, 1);

        // Single A stream of six words.
        do_reset(1);
        a_v = 1; b_v = 0; o_r = 1; a_d = 32'h11;
        for (int i = 0; i < 8; i++) begin
            a_v = (n_a < 6);
            cycle();
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_data", out_data, 32'h10 + i - 1);
                chk("stream_src", out_src, 0);
            end
        end

        // Burst fairness with both requesters saturated.
        do_reset(1);
        a_v = 1; b_v = 1; o_r = 1; a_d = 32'hA000; b_d = 32'hB000;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i >= 2) begin
                chk("burst_nobubble", out_valid, 1);
                chk("burst_src", out_src, ((i - 2) / MAXB) % 2);
                chk("burst_onehot", sel1 & sel2, 0);
            end
        end

        // Backpressure after two A transfers.
        do_reset(1);
        a_v = 1; b_v = 1; o_r = 1; a_d = 32'hA0; b_d = 32'hB0;
        repeat (3) cycle();
        o_r = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_a_ready", a_ready, 0);
            chk("bp_hold_data", out_data, 32'hA1);
        end
        o_r = 1;
        repeat (3) cycle();
        cycle();
        chk("bp_switch_data", out_data, 32'hB0);
        chk("bp_switch_src", out_src, 1);

        // Owner drops valid while B waits.
        do_reset(1);
        a_v = 1; b_v = 1; o_r = 1; a_d = 32'hC0; b_d = 32'hD0;
        cycle();
        cycle();
        a_v = 0;
        cycle();
        cycle();
        chk("drop_own_b", sel2, 1);
        cycle();
        chk("drop_src", out_src, 1);
        chk("drop_data", out_data, 32'hD0);

`ifdef ARB_STATS_EN
        do_reset(1);
        a_v = 1; b_v = 0; o_r = 1; a_d = 32'h1; b_d = 32'h2;
        for (int k = 0; k < 40 && n_a < 10; k++) cycle();
        a_v = 0; b_v = 1;
        for (int k = 0; k < 40 && n_b < 7; k++) cycle();
        b_v = 0;
        cycle();
        chk("stats_a10", a_count, 10);
        chk("stats_b7", b_count, 7);
        clr = 1;
        cycle();
        clr = 0;
        cycle();
        chk("stats_clr_a", a_count, 0);
        chk("stats_clr_b", b_count, 0);
`endif

        // Randomized traffic; valid is held with stable data until accepted.
        do_reset(1);
        a_v = 0; b_v = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset(1 + $urandom_range(2));
                a_v = 0; b_v = 0;
            end
            if (!(a_v && !last_acc_a)) begin
                a_v = ($urandom_range(9) < 6);
                a_d = $urandom;
            end
            if (!(b_v && !last_acc_b)) begin
                b_v = ($urandom_range(9) < 6);
                b_d = $urandom;
            end
            o_r = ($urandom_range(3) != 0);
            clr = ($urandom_range(49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
